// File: rtl/mdu_if.sv
// Bundle of the MDU's operation/handshake signals shared between the core and the unit.
interface mdu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_by_zero;

  modport master (
    output start, op, a, b, mthi, mtlo, wdata,
    input  busy, done, hi, lo, div_by_zero
  );

  modport slave (
    input  start, op, a, b, mthi, mtlo, wdata,
    output busy, done, hi, lo, div_by_zero
  );
endinterface

// File: rtl/mdu.sv
// Iterative MIPS multiply/divide unit: one product/quotient bit per cycle into HI/LO.
module mdu #(
  parameter int WIDTH = 32
) (
  input  logic  clk,
  input  logic  reset,
  mdu_if.slave  bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic             r_is_div;
  logic             r_negq;
  logic             r_negr;
  logic             r_dbz_pend;
  logic [WIDTH-1:0] r_opnd;
  logic [WIDTH:0]   r_acc;
  logic [WIDTH-1:0] r_shf;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_done;
  logic             r_dbz;

  logic             w_signed;
  logic             w_bzero;
  logic             w_start;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_rsh;
  logic [WIDTH:0]   w_diff;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0] w_quo_fix;
  logic [WIDTH-1:0] w_rem_fix;

  assign w_signed = ~bus.op[0];
  assign w_bzero  = (bus.b == '0);
  assign w_start  = (r_state == S_IDLE) && bus.start;
  assign w_abs_a  = (w_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign w_abs_b  = (w_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;

  // Multiply step: accumulator is the upper product half, r_shf the lower half/multiplier.
  assign w_sum = r_acc + (r_shf[0] ? {1'b0, r_opnd} : '0);

  // Divide step: r_acc is the partial remainder, r_shf shifts dividend out / quotient in.
  assign w_rsh  = {r_acc[WIDTH-1:0], r_shf[WIDTH-1]};
  assign w_diff = w_rsh - {1'b0, r_opnd};

  assign w_prod     = {r_acc[WIDTH-1:0], r_shf};
  assign w_prod_fix = r_negq ? -w_prod : w_prod;
  assign w_quo_fix  = r_negq ? -r_shf : r_shf;
  assign w_rem_fix  = r_negr ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (bus.start) w_next = S_CALC;
      S_CALC: if (r_cnt == CW'(WIDTH - 1)) w_next = S_FIX;
      S_FIX:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // A zero divisor latches the raw dividend and skips sign fixing, so the
  // unrestored iteration leaves HI = a and LO = all ones by itself.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt      <= '0;
      r_is_div   <= 1'b0;
      r_negq     <= 1'b0;
      r_negr     <= 1'b0;
      r_dbz_pend <= 1'b0;
      r_opnd     <= '0;
      r_acc      <= '0;
      r_shf      <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_done     <= 1'b0;
      r_dbz      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_start) begin
        r_cnt      <= '0;
        r_is_div   <= bus.op[1];
        r_dbz_pend <= bus.op[1] & w_bzero;
        r_negq     <= w_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]) & ~(bus.op[1] & w_bzero);
        r_negr     <= (bus.op == 2'b10) & bus.a[WIDTH-1] & ~w_bzero;
        r_acc      <= '0;
        if (bus.op[1]) begin
          r_shf  <= w_bzero ? bus.a : w_abs_a;
          r_opnd <= w_abs_b;
        end else begin
          r_shf  <= w_abs_b;
          r_opnd <= w_abs_a;
        end
      end else if (r_state == S_IDLE) begin
        if (bus.mthi) r_hi <= bus.wdata;
        if (bus.mtlo) r_lo <= bus.wdata;
      end else if (r_state == S_CALC) begin
        r_cnt <= r_cnt + CW'(1);
        if (r_is_div) begin
          r_acc <= w_diff[WIDTH] ? w_rsh : w_diff;
          r_shf <= {r_shf[WIDTH-2:0], ~w_diff[WIDTH]};
        end else begin
          r_acc <= {1'b0, w_sum[WIDTH:1]};
          r_shf <= {w_sum[0], r_shf[WIDTH-1:1]};
        end
      end else begin
        if (r_is_div) begin
          r_hi <= w_rem_fix;
          r_lo <= w_quo_fix;
        end else begin
          r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
          r_lo <= w_prod_fix[WIDTH-1:0];
        end
        r_dbz  <= r_dbz_pend;
        r_done <= 1'b1;
      end
    end
  end

  assign bus.busy        = (r_state != S_IDLE);
  assign bus.done        = r_done;
  assign bus.hi          = r_hi;
  assign bus.lo          = r_lo;
  assign bus.div_by_zero = r_dbz;
endmodule
